// File: rtl/adc_pkg.sv
// Shared definitions for the ADC1410 capture path.
// Holds the default channel/coefficient widths shared with the adc1410
// wrapper, the offset-calibration sequencer state encoding and the
// channel-select encodings.
package adc_pkg;

  localparam int unsigned ADC_CHDATA_SIZE_DFLT = 16;
  localparam int unsigned ADC_CALIB_SIZE_DFLT  = 18;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_COMPUTE = 2'd3
  } calib_state_t;

  typedef enum logic {
    CH_SEL_1 = 1'b0,
    CH_SEL_2 = 1'b1
  } ch_sel_t;

endpackage

// File: rtl/adc_offset_calib_if.sv
// Control bundle between system control logic and the offset-calibration
// sequencer.
//   i_start        request calibration (sampled only while idle)
//   i_ch_sel       0 = channel 1, 1 = channel 2
//   o_calib_value  additive coefficient for the ADC wrapper (signed)
//   o_busy         calibration in progress
//   o_done         one-cycle pulse, new coefficient valid
//   o_abort        one-cycle pulse, calibration aborted
// master: system control side; slave: sequencer side.
interface adc_offset_calib_if #(
  parameter int unsigned CALIB_W = adc_pkg::ADC_CALIB_SIZE_DFLT
);

  logic               i_start;
  logic               i_ch_sel;
  logic [CALIB_W-1:0] o_calib_value;
  logic               o_busy;
  logic               o_done;
  logic               o_abort;

  modport master (
    output i_start, i_ch_sel,
    input  o_calib_value, o_busy, o_done, o_abort
  );

  modport slave (
    input  i_start, i_ch_sel,
    output o_calib_value, o_busy, o_done, o_abort
  );

endinterface

// File: rtl/adc_sample_accumulator.sv
// Signed clear/accumulate register with a sample-count down-counter.
//   i_clk      clock (rising edge)
//   i_reset    synchronous active-high reset
//   i_clear    zero the accumulator and load the count with 2^LOG2_N
//   i_en       add sign-extended i_sample, decrement the count
//   i_sample   signed sample word
//   o_acc      signed running sum (DATA_W + LOG2_N bits, cannot overflow)
//   o_last     terminal count: the sample accepted this cycle is the last
module adc_sample_accumulator #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LOG2_N = 10
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_clear,
  input  logic                           i_en,
  input  logic signed [DATA_W-1:0]       i_sample,
  output logic signed [DATA_W+LOG2_N-1:0] o_acc,
  output logic                           o_last
);

  localparam int unsigned ACC_W = DATA_W + LOG2_N;
  localparam int unsigned CNT_W = LOG2_N + 1;
  localparam logic [CNT_W-1:0] N_LOAD = {1'b1, {LOG2_N{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic signed [ACC_W-1:0] r_acc;
  logic        [CNT_W-1:0] r_cnt;
  logic signed [ACC_W-1:0] w_sample_ext;

  assign w_sample_ext = {{LOG2_N{i_sample[DATA_W-1]}}, i_sample};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_acc <= '0;
      r_cnt <= N_LOAD;
    end else if (i_en) begin
      r_acc <= r_acc + w_sample_ext;
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_cnt == CNT_ONE);

endmodule

// File: rtl/adc_offset_calib.sv
// Automatic DC-offset calibration sequencer for the ADC1410 capture path.
// On an accepted start the additive coefficient is forced to zero, the
// pipeline is allowed SETTLE_CYCLES cycles to settle, 2^LOG2_SAMPLES raw
// samples of the selected channel are summed, and the negated floor mean
// is driven as the new coefficient. Loss of i_init_done mid-run restores
// the coefficient that was in force before the run.
//   i_sys_clock  system clock (rising edge)
//   i_reset      synchronous active-high reset
//   i_init_done  ADC controller initialised
//   i_data_ch1   channel 1 samples (signed)
//   i_data_ch2   channel 2 samples (signed)
//   ctrl         start/select in, coefficient/busy/done/abort out
module adc_offset_calib
  import adc_pkg::*;
#(
  parameter int unsigned ADC_CHDATA_SIZE = ADC_CHDATA_SIZE_DFLT,
  parameter int unsigned ADC_CALIB_SIZE  = ADC_CALIB_SIZE_DFLT,
  parameter int unsigned LOG2_SAMPLES    = 10,
  parameter int unsigned SETTLE_CYCLES   = 64
) (
  input  logic                       i_sys_clock,
  input  logic                       i_reset,
  input  logic                       i_init_done,
  input  logic [ADC_CHDATA_SIZE-1:0] i_data_ch1,
  input  logic [ADC_CHDATA_SIZE-1:0] i_data_ch2,
  adc_offset_calib_if.slave          ctrl
);

  localparam int unsigned ACC_W = ADC_CHDATA_SIZE + LOG2_SAMPLES;
  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

  calib_state_t              r_state;
  ch_sel_t                   r_ch_sel;
  logic [SET_W-1:0]          r_settle_cnt;
  logic [ADC_CALIB_SIZE-1:0] r_prev_calib;
  logic [ADC_CALIB_SIZE-1:0] r_calib;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_abort;

  calib_state_t              w_state_next;
  ch_sel_t                   w_ch_sel_next;
  logic [SET_W-1:0]          w_settle_next;
  logic [ADC_CALIB_SIZE-1:0] w_prev_next;
  logic [ADC_CALIB_SIZE-1:0] w_calib_next;
  logic                      w_busy_next;
  logic                      w_done_next;
  logic                      w_abort_next;
  logic                      w_acc_clear;
  logic                      w_acc_en;

  logic signed [ADC_CHDATA_SIZE-1:0] w_sample;
  logic signed [ACC_W-1:0]           w_acc;
  logic                              w_acc_last;
  logic signed [ACC_W-1:0]           w_neg_mean;
  logic signed [ADC_CALIB_SIZE-1:0]  w_calib_new;

  assign w_sample = (r_ch_sel == CH_SEL_2) ? i_data_ch2 : i_data_ch1;

  adc_sample_accumulator #(
    .DATA_W (ADC_CHDATA_SIZE),
    .LOG2_N (LOG2_SAMPLES)
  ) u_accum (
    .i_clk    (i_sys_clock),
    .i_reset  (i_reset),
    .i_clear  (w_acc_clear),
    .i_en     (w_acc_en),
    .i_sample (w_sample),
    .o_acc    (w_acc),
    .o_last   (w_acc_last)
  );

  // Arithmetic shift floors toward -inf; negating in the accumulator width
  // keeps +32768 representable before resizing to the coefficient width.
  always_comb begin
    w_neg_mean  = -(w_acc >>> LOG2_SAMPLES);
    w_calib_new = ADC_CALIB_SIZE'(w_neg_mean);
  end

  always_comb begin
    w_state_next  = r_state;
    w_ch_sel_next = r_ch_sel;
    w_settle_next = r_settle_cnt;
    w_prev_next   = r_prev_calib;
    w_calib_next  = r_calib;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_abort_next  = 1'b0;
    w_acc_clear   = 1'b0;
    w_acc_en      = 1'b0;

    // Abort outranks every in-run transition, including the COMPUTE update.
    if (r_state != ST_IDLE && !i_init_done) begin
      w_state_next = ST_IDLE;
      w_calib_next = r_prev_calib;
      w_busy_next  = 1'b0;
      w_abort_next = 1'b1;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (ctrl.i_start && i_init_done) begin
            w_ch_sel_next = ch_sel_t'(ctrl.i_ch_sel);
            w_prev_next   = r_calib;
            w_calib_next  = '0;
            w_busy_next   = 1'b1;
            w_settle_next = SETTLE_LOAD;
            w_state_next  = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          w_settle_next = r_settle_cnt - SETTLE_ONE;
          if (r_settle_cnt == SETTLE_ONE) begin
            w_acc_clear  = 1'b1;
            w_state_next = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          w_acc_en = 1'b1;
          if (w_acc_last) begin
            w_state_next = ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          w_calib_next = w_calib_new;
          w_done_next  = 1'b1;
          w_busy_next  = 1'b0;
          w_state_next = ST_IDLE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_sys_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_ch_sel     <= CH_SEL_1;
      r_settle_cnt <= '0;
      r_prev_calib <= '0;
      r_calib      <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_ch_sel     <= w_ch_sel_next;
      r_settle_cnt <= w_settle_next;
      r_prev_calib <= w_prev_next;
      r_calib      <= w_calib_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_abort      <= w_abort_next;
    end
  end

  assign ctrl.o_calib_value = r_calib;
  assign ctrl.o_busy        = r_busy;
  assign ctrl.o_done        = r_done;
  assign ctrl.o_abort       = r_abort;

endmodule

// File: tb/tb_adc_offset_calib.sv
// Scoreboard bench for adc_offset_calib (LOG2_SAMPLES=4, SETTLE_CYCLES=4).
module tb_adc_offset_calib;

  localparam int S = 4;
  localparam int N = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic [15:0] d1, d2;

  adc_offset_calib_if #(.CALIB_W(18)) ctrl ();

  adc_offset_calib #(
    .ADC_CHDATA_SIZE (16),
    .ADC_CALIB_SIZE  (18),
    .LOG2_SAMPLES    (4),
    .SETTLE_CYCLES   (4)
  ) dut (
    .i_sys_clock (clk),
    .i_reset     (rst),
    .i_init_done (init_done),
    .i_data_ch1  (d1),
    .i_data_ch2  (d2),
    .ctrl        (ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_abort;
    logic [17:0] value;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [17:0] model_calib;
  int          busy_cnt = 0;
  bit          nz_during_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Reference: coefficient = -floor(sum / N), computed with plain integers.
  function automatic logic [17:0] ref_calib(input int sum);
    int mean;
    if (sum >= 0) mean = sum / N;
    else          mean = -((-sum + N - 1) / N);
    return 18'(-mean);
  endfunction

  function automatic void gen(input int mode, input int c, output logic [15:0] a, output logic [15:0] b);
    a = 16'($urandom);
    b = 16'($urandom);
    case (mode)
      0: a = 16'd100;
      1: b = 16'h8000;
      2: a = (c % 2 != 0) ? 16'd11 : 16'd10;
      3: a = (c % 2 != 0) ? 16'hFFFD : 16'hFFFC;
      default: ;
    endcase
  endfunction

  // Monitor: pops the scoreboard on every done/abort pulse.
  always @(negedge clk) begin
    if (ctrl.o_done || ctrl.o_abort) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: done=%0b abort=%0b, expected no pulse", ctrl.o_done, ctrl.o_abort);
      end else begin
        mon_e = q.pop_front();
        check("pulse_is_abort", 32'(ctrl.o_abort), 32'(mon_e.is_abort));
        check("pulse_is_done", 32'(ctrl.o_done), 32'(!mon_e.is_abort));
        check("calib_value", 32'(ctrl.o_calib_value), 32'(mon_e.value));
        check("busy_after_pulse", 32'(ctrl.o_busy), 32'd0);
        if (!mon_e.is_abort) begin
          check("busy_cycles", 32'(busy_cnt), 32'(S + N + 1));
          check("calib_zero_during_run", 32'(nz_during_run), 32'd0);
        end
      end
    end
    if (ctrl.o_busy) begin
      busy_cnt++;
      if (ctrl.o_calib_value != 18'd0) nz_during_run = 1;
    end else begin
      busy_cnt = 0;
      nz_during_run = 0;
    end
  end

  // One calibration attempt. Edge 0 accepts the start; edges S+1..S+N
  // sample; edge S+N+1 publishes. abort_c/reset_c name the edge at which
  // init_done is seen low / reset is seen high (-1 = none).
  task automatic run_calib(input bit ch, input int mode, input int abort_c, input int reset_c, input bit repulse);
    int          sum = 0;
    logic [15:0] n1, n2;
    exp_t        e;
    gen(mode, 0, n1, n2);
    d1 = n1;
    d2 = n2;
    ctrl.i_start  = 1'b1;
    ctrl.i_ch_sel = ch;
    init_done     = 1'b1;
    if (abort_c >= 0) begin
      e.is_abort = 1'b1;
      e.value    = model_calib;
      q.push_back(e);
    end
    for (int c = 0; c <= S + N + 3; c++) begin
      @(posedge clk);
      #1;
      if (c >= S + 1 && c <= S + N)
        sum += ch ? int'($signed(d2)) : int'($signed(d1));
      ctrl.i_start = repulse && (c == 1 || c == S + 2);
      if (c == S + N && abort_c < 0 && reset_c < 0) begin
        e.is_abort  = 1'b0;
        e.value     = ref_calib(sum);
        model_calib = e.value;
        q.push_back(e);
      end
      if (c == abort_c) init_done = 1'b1;
      if (abort_c >= 0 && c == abort_c - 1) init_done = 1'b0;
      if (reset_c >= 0 && c == reset_c - 1) rst = 1'b1;
      if (c == reset_c) begin
        rst = 1'b0;
        check("rst_busy", 32'(ctrl.o_busy), 32'd0);
        check("rst_done", 32'(ctrl.o_done), 32'd0);
        check("rst_abort", 32'(ctrl.o_abort), 32'd0);
        check("rst_calib", 32'(ctrl.o_calib_value), 32'd0);
        q.delete();
        model_calib = '0;
      end
      gen(mode, c + 1, n1, n2);
      d1 = n1;
      d2 = n2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    init_done     = 1'b0;
    ctrl.i_start  = 1'b0;
    ctrl.i_ch_sel = 1'b0;
    d1            = '0;
    d2            = '0;
    model_calib   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(ctrl.o_busy), 32'd0);
    check("reset_done", 32'(ctrl.o_done), 32'd0);
    check("reset_abort", 32'(ctrl.o_abort), 32'd0);
    check("reset_calib", 32'(ctrl.o_calib_value), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_calib(1'b0, 0, -1, -1, 1'b0);
    check("const100_idle_calib", 32'(ctrl.o_calib_value), 32'h3FF9C);
    run_calib(1'b1, 1, -1, -1, 1'b0);
    check("ch2_min_idle_calib", 32'(ctrl.o_calib_value), 32'h08000);
    run_calib(1'b0, 2, -1, -1, 1'b0);
    check("alt_10_11_calib", 32'(ctrl.o_calib_value), 32'h3FFF6);
    run_calib(1'b0, 3, -1, -1, 1'b0);
    check("alt_m3_m4_calib", 32'(ctrl.o_calib_value), 32'h00004);
    run_calib(1'b0, 0, -1, -1, 1'b0);
    run_calib(1'b0, 4, S + 5, -1, 1'b0);
    check("abort_restored_calib", 32'(ctrl.o_calib_value), 32'h3FF9C);
    run_calib(1'b1, 4, -1, -1, 1'b1);

    ctrl.i_start = 1'b1;
    init_done    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("start_no_init_busy", 32'(ctrl.o_busy), 32'd0);
    end
    ctrl.i_start = 1'b0;
    init_done    = 1'b1;

    run_calib(1'b0, 4, S + N + 1, -1, 1'b0);
    run_calib(1'b0, 4, -1, S + 6, 1'b0);
    run_calib(1'b0, 0, -1, -1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      if ($urandom_range(0, 2) == 0)
        run_calib(1'($urandom), 4, int'($urandom_range(1, S + N + 1)), -1, 1'b0);
      else
        run_calib(1'($urandom), 4, -1, -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_offset_calib.md
Name: adc_offset_calib

Overview:
Automatic DC-offset calibration sequencer for the ADC1410 capture path. On request it forces the controller's additive calibration coefficient to zero and waits for the pipeline to settle. It then averages 2^LOG2_SAMPLES raw samples from the selected channel and drives the negated mean as the 18-bit additive coefficient (the calib value input of the ADC1410 wrapper). It sits between system control logic and the ADC wrapper, in the i_sys_clock domain.

Parameters:
ADC_CHDATA_SIZE, 16, width of channel sample words (signed two's complement)
ADC_CALIB_SIZE, 18, width of the additive calibration coefficient (signed)
LOG2_SAMPLES, 10, log2 of the number of samples averaged (valid range 1..16)
SETTLE_CYCLES, 64, cycles to wait after zeroing the coefficient before accumulating (must be >= 1)

Ports:
i_sys_clock  input  1  system clock; all logic on rising edge
i_reset  input  1  synchronous, active-high reset
i_start  input  1  request calibration; sampled only in IDLE
i_ch_sel  input  1  0 = channel 1, 1 = channel 2; captured at start acceptance
i_init_done  input  1  ADC controller initialised (active-high)
i_data_ch1  input  ADC_CHDATA_SIZE  channel 1 samples, one per cycle
i_data_ch2  input  ADC_CHDATA_SIZE  channel 2 samples, one per cycle
o_calib_value  output  ADC_CALIB_SIZE  additive coefficient to the ADC wrapper
o_busy  output  1  calibration in progress
o_done  output  1  one-cycle pulse: new coefficient valid
o_abort  output  1  one-cycle pulse: calibration aborted

Behaviour:
- Reset: state IDLE; o_calib_value = 0, o_busy = 0, o_done = 0, o_abort = 0; accumulator, counter and saved coefficient cleared. Reset mid-operation returns to IDLE with the same values; no pulse is emitted.
- States: IDLE, SETTLE, ACCUM, COMPUTE.
- IDLE: if i_start && i_init_done, then on the next edge:
  - capture i_ch_sel;
  - save the current o_calib_value to prev_calib;
  - set o_calib_value = 0 and o_busy = 1;
  - load counter = SETTLE_CYCLES;
  - go to SETTLE.
  - i_start with i_init_done = 0 is ignored, with no pulse.
- SETTLE: decrement the counter each cycle. When counter == 1, clear the accumulator, load counter = 2^LOG2_SAMPLES and go to ACCUM. Duration is exactly SETTLE_CYCLES cycles.
- ACCUM: each cycle, add the sign-extended selected sample to the accumulator and decrement the counter. Exactly 2^LOG2_SAMPLES samples are summed. After the last sample, go to COMPUTE.
  - Accumulator width is ADC_CHDATA_SIZE + LOG2_SAMPLES, signed; it cannot overflow.
- COMPUTE (one cycle):
  - mean = accumulator >>> LOG2_SAMPLES, arithmetic shift, i.e. floor toward negative infinity.
  - o_calib_value <= -(mean) sign-extended to ADC_CALIB_SIZE. The range is -32767..+32768, so no saturation is required.
  - Assert o_done for one cycle, drop o_busy, and return to IDLE, all on the same edge.
- Latency from the accepting edge to the o_done edge is SETTLE_CYCLES + 2^LOG2_SAMPLES + 1 cycles.
- i_start while busy is ignored; it is not queued.
- i_init_done falling in SETTLE, ACCUM or COMPUTE aborts the run. On the next edge:
  - o_calib_value <= prev_calib;
  - pulse o_abort for one cycle;
  - o_busy = 0;
  - go to IDLE.
  - Abort takes priority over the COMPUTE update.
- o_calib_value changes only at start acceptance, in COMPUTE, on abort, or at reset. It is held stable otherwise.
- All outputs are registered.

Decomposition:
- Shared package adc_pkg holds:
  - state encoding constants (IDLE, SETTLE, ACCUM, COMPUTE);
  - ADC_CHDATA_SIZE and ADC_CALIB_SIZE defaults, shared with the adc1410 wrapper;
  - the channel-select encodings.
- One natural sub-module: adc_sample_accumulator. It is a signed clear/accumulate register with a sample-count down-counter and a terminal-count flag; the FSM stays in the top module.

Test Plan:
(All scenarios use LOG2_SAMPLES=4 and SETTLE_CYCLES=4.)
1. Ch1 held at constant 100, i_ch_sel=0, start pulse -> o_busy for 21 cycles, o_done pulse, o_calib_value = -100 = 18'h3FF9C; o_calib_value = 0 during the run.
2. Ch2 held at -32768 (16'h8000), i_ch_sel=1 -> o_calib_value = +32768 = 18'h08000; ch1 activity has no effect.
3. Ch1 alternating 10, 11 -> sum 168, mean 10 -> o_calib_value = 18'h3FFF6. Ch1 alternating -3, -4 -> sum -56, mean -4 (floor) -> o_calib_value = 18'h00004.
4. After a completed run with calib = 18'h3FF9C, start again and drop i_init_done during ACCUM -> o_abort pulse the next cycle, o_busy low, o_calib_value restored to 18'h3FF9C, no o_done.
5. i_start re-pulsed during SETTLE and ACCUM -> ignored; exactly one o_done. i_start with i_init_done=0 -> nothing happens.
6. Assert i_reset for one cycle mid-ACCUM -> next cycle all outputs 0 and state IDLE; a fresh start then completes normally with the correct value.
